// File: rtl/max_unpool_stream.sv
// max_unpool_stream: streaming 2x2 max-unpool (or nearest upsample) with a one-pooled-row line buffer
module max_unpool_stream #(
  parameter int POOL_H    = 32,
  parameter int POOL_W    = 31,
  parameter int CHANNELS  = 32,
  parameter int BIT_WIDTH = 16,
  parameter int NEAREST   = 0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [CHANNELS*BIT_WIDTH-1:0] in_data,
  input  logic [CHANNELS*2-1:0]         in_idx,
  input  logic                          in_valid,
  output logic                          in_ready,
  output logic [CHANNELS*BIT_WIDTH-1:0] out_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic                          out_eol,
  output logic                          out_last
);
  localparam int OCW = $clog2(2*POOL_W);
  localparam int PRW = POOL_H > 1 ? $clog2(POOL_H) : 1;
  localparam int EW  = CHANNELS*(BIT_WIDTH+2);
  localparam logic [OCW-1:0] OC_LAST = OCW'(2*POOL_W-1);
  localparam logic [PRW-1:0] PR_LAST = PRW'(POOL_H-1);
  typedef enum logic {TOP, BOT} st_t;
  st_t            st;
  logic [OCW-1:0] oc;
  logic [PRW-1:0] pr;
  logic [EW-1:0]  hold, src;
  logic [EW-1:0]  lb [POOL_W];
  logic           pass, fire;
  assign pass      = st == TOP && !oc[0];
  assign in_ready  = !rst && pass && out_ready;
  assign out_valid = !rst && (pass ? in_valid : 1'b1);
  assign fire      = out_valid && out_ready;
  assign src       = pass ? {in_data, in_idx} : st == TOP ? hold : lb[oc[OCW-1:1]];
  assign out_eol   = oc == OC_LAST;
  assign out_last  = st == BOT && out_eol && pr == PR_LAST;
  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    assign out_data[c*BIT_WIDTH +: BIT_WIDTH] =
      (NEAREST != 0 || src[c*2 +: 2] == {oc[0], st == BOT}) ? src[2*CHANNELS + c*BIT_WIDTH +: BIT_WIDTH] : '0;
  end
  // capture the pooled pixel for the odd top beat and the bottom row
  always_ff @(posedge clk)
    if (fire && pass) begin
      lb[oc[OCW-1:1]] <= {in_data, in_idx};
      hold            <= {in_data, in_idx};
    end
  // output raster position: column, top/bottom half, pooled row
  always_ff @(posedge clk)
    if (rst) begin
      st <= TOP;
      oc <= '0;
      pr <= '0;
    end else if (fire) begin
      oc <= out_eol ? '0 : oc + 1'b1;
      if (out_eol) st <= st == TOP ? BOT : TOP;
      if (out_eol && st == BOT) pr <= pr == PR_LAST ? '0 : pr + 1'b1;
    end
endmodule

// File: tb/tb_max_unpool_stream.sv
// tb_max_unpool_stream: directed checks of the small-config unpool stream
module tb_max_unpool_stream;
  logic        clk = 0, rst = 1;
  logic [31:0] in_data = 0, out_data, n_out_data;
  logic [3:0]  in_idx = 0;
  logic        in_valid = 0, in_ready, out_valid, out_ready = 1, out_eol, out_last;
  logic        n_in_ready, n_out_valid, n_out_eol, n_out_last;
  int          checks = 0, errors = 0, cnt = 0, cyc = 0, nchk = 0, ebase;
  logic [31:0] q_data [256];
  logic        q_eol [256], q_last [256];
  int          q_cyc [256];
  logic [31:0] pd [5][4];
  logic [3:0]  pi [5][4];
  always #5 clk = ~clk;
  max_unpool_stream #(.POOL_H(2), .POOL_W(2), .CHANNELS(2), .BIT_WIDTH(16), .NEAREST(0)) u_dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_idx(in_idx), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .out_eol(out_eol), .out_last(out_last));
  max_unpool_stream #(.POOL_H(2), .POOL_W(2), .CHANNELS(2), .BIT_WIDTH(16), .NEAREST(1)) u_near (
    .clk(clk), .rst(rst), .in_data(32'h7FFF7FFF), .in_idx(4'b1001), .in_valid(1'b1), .in_ready(n_in_ready),
    .out_data(n_out_data), .out_valid(n_out_valid), .out_ready(1'b1), .out_eol(n_out_eol), .out_last(n_out_last));
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  function automatic logic [31:0] exp_data(input int f, input int k);
    int r = k / 4, c = k % 4;
    int p = (r / 2) * 2 + c / 2;
    logic [1:0] sel = 2'(((c % 2) << 1) | (r % 2));
    logic [31:0] d = pd[f][p];
    logic [3:0] ix = pi[f][p];
    exp_data = 0;
    for (int ch = 0; ch < 2; ch++)
      if (ix[ch*2 +: 2] == sel) exp_data[ch*16 +: 16] = d[ch*16 +: 16];
  endfunction
  always @(posedge clk) cyc++;
  always @(negedge clk)
    if (!rst && out_valid && out_ready) begin
      q_data[cnt] = out_data;
      q_eol[cnt]  = out_eol;
      q_last[cnt] = out_last;
      q_cyc[cnt]  = cyc;
      cnt++;
    end
  always @(negedge clk)
    if (!rst && n_out_valid && nchk < 16) begin
      check("nearest", n_out_data, 32'h7FFF7FFF);
      nchk++;
    end
  task automatic wait_cnt(input int n);
    for (int t = 0; t < 600 && cnt < n; t++) begin
      @(negedge clk);
      #1;
    end
    if (cnt < n) check("timeout", cnt, n);
  endtask
  task automatic send_pix(input int f, input int p);
    in_data  = pd[f][p];
    in_idx   = pi[f][p];
    in_valid = 1;
    for (int t = 0; t < 600; t++) begin
      @(negedge clk);
      if (in_ready) break;
    end
    @(posedge clk);
    #1;
    in_valid = 0;
  endtask
  task automatic gap_pix(input int f, input int p, input int b);
    wait_cnt(b);
    @(posedge clk);
    #1;
    repeat (3) begin
      @(negedge clk);
      check("gap_ov", out_valid, 0);
    end
    @(posedge clk);
    #1;
    send_pix(f, p);
  endtask
  task automatic stall_at(input int b, input int f, input int k);
    wait_cnt(b);
    @(posedge clk);
    #1;
    out_ready = 0;
    repeat (5) begin
      @(negedge clk);
      check("stall_d", out_data, exp_data(f, k));
      check("stall_eol", out_eol, k % 4 == 3);
      check("stall_ir", in_ready, 0);
      check("stall_ov", out_valid, 1);
    end
    @(posedge clk);
    #1;
    out_ready = 1;
  endtask
  task automatic check_frame(input int f, input int base, input string tag);
    wait_cnt(base + 16);
    for (int k = 0; k < 16; k++) begin
      check($sformatf("%s_d%0d", tag, k), q_data[base+k], exp_data(f, k));
      check($sformatf("%s_eol%0d", tag, k), q_eol[base+k], k % 4 == 3);
      check($sformatf("%s_last%0d", tag, k), q_last[base+k], k == 15);
    end
  endtask
  initial begin
    pd[0] = '{32'h01010011, 32'h02020022, 32'h03030033, 32'h04040044};
    pi[0] = '{4'b0000, 4'b0000, 4'b0000, 4'b0000};
    pd[1] = '{32'h0BBB0AAA, 32'h12345678, 32'hFFFF8000, 32'h0001CAFE};
    pi[1] = '{4'b0111, 4'b1000, 4'b1111, 4'b0010};
    pd[2] = '{32'h11112222, 32'h33334444, 32'h55556666, 32'h77778888};
    pi[2] = '{4'b0110, 4'b1101, 4'b0001, 4'b1110};
    pd[3] = '{32'hDEADBEEF, 32'h0F0FF0F0, 32'h0, 32'h0};
    pi[3] = '{4'b0000, 4'b0101, 4'b0000, 4'b0000};
    pd[4] = '{32'h0E010E02, 32'h0E030E04, 32'h0E050E06, 32'h0E070E08};
    pi[4] = '{4'b0000, 4'b1011, 4'b0100, 4'b1111};
    in_valid = 1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_ir", in_ready, 0);
    check("reset_ov", out_valid, 0);
    @(posedge clk);
    #1;
    rst = 0;
    in_valid = 0;
    for (int f = 0; f < 2; f++)
      for (int p = 0; p < 4; p++) send_pix(f, p);
    check_frame(0, 0, "A");
    check_frame(1, 16, "B");
    check("A_b0", q_data[0], 32'h01010011);
    check("A_b1", q_data[1], 32'h0);
    check("A_b2", q_data[2], 32'h02020022);
    check("A_b4", q_data[4], 32'h0);
    check("A_b8", q_data[8], 32'h03030033);
    check("B_b0", q_data[16], 32'h0);
    check("B_b1", q_data[17], 32'h0);
    check("B_b4", q_data[20], 32'h0BBB0000);
    check("B_b5", q_data[21], 32'h00000AAA);
    check("b2b", q_cyc[16] - q_cyc[15], 1);
    fork
      begin
        gap_pix(2, 0, 32);
        gap_pix(2, 1, 34);
        gap_pix(2, 2, 40);
        gap_pix(2, 3, 42);
      end
      begin
        stall_at(33, 2, 1);
        stall_at(38, 2, 6);
      end
    join
    check_frame(2, 32, "C");
    send_pix(3, 0);
    send_pix(3, 1);
    wait_cnt(54);
    @(posedge clk);
    #1;
    rst = 1;
    in_data = pd[4][0];
    in_idx = pi[4][0];
    in_valid = 1;
    @(negedge clk);
    check("rst_ir", in_ready, 0);
    check("rst_ov", out_valid, 0);
    @(posedge clk);
    #1;
    rst = 0;
    in_valid = 0;
    ebase = cnt;
    check("rst_base", ebase, 54);
    for (int p = 0; p < 4; p++) send_pix(4, p);
    check_frame(4, ebase, "E");
    check("E_first", q_data[ebase], 32'h0E010E02);
    check("near_cnt", nchk, 16);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
